adc_readout_scheduler: RTL and testbench

// - Sequences readout of the decimated delta-sigma ADC channels (A, B, A-B) onto ONE shared serial pin.
// - Snapshots all channel words on the same CIC output strobe, then time-multiplexes them MSB-first, channel 0 first.
// - Sits between the CIC filter outputs and uo_out; replaces one-serialiser-per-channel readout.
// - Readout starts from an external trigger or a free-running decimation-period counter.

---
 rtl/adc_readout_scheduler.sv | 169 ++++++++++++++++
 tb/tb_adc_readout_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_scheduler.sv
// Snapshots NCH decimated channel words on a CIC strobe and shifts them MSB-first onto one serial pin.
// Optional build macro: PARITY_EN appends an even-parity bit after every word.
module adc_readout_scheduler #(
  parameter int NCH      = 3,
  parameter int WIDTH    = 16,
  parameter int GAP      = 2,
  parameter int AUTO_DIV = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cic_valid,
  input  logic [NCH*WIDTH-1:0]   ch_data,
  input  logic                   trig,
  input  logic                   auto_en,
  output logic                   ser_out,
  output logic                   word_start,
  output logic [1:0]             ch_id,
  output logic                   busy,
  output logic                   overrun,
  output logic [1:0]             dbg_state
);

`ifdef PARITY_EN
  localparam int WLEN = WIDTH + 1;
`else
  localparam int WLEN = WIDTH;
`endif
  localparam int PW = $clog2(WLEN + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int FW = NCH * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SHIFT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d, snap_order;
  logic [PW-1:0]   pos_q, pos_d;
  logic [1:0]      ch_q, ch_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            par_q, par_d;
  logic            trig_s1, trig_s2, trig_s3;
  logic [AW-1:0]   auto_cnt;
  logic            trig_req, auto_wrap, req, data_phase;

  // Handshake: cic_valid is a one-cycle strobe with no back-pressure; a set not
  // captured in ARM is simply lost, and req is a one-cycle pulse never held.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
    end
  end

  assign trig_req  = trig_s2 & ~trig_s3;
  assign auto_wrap = cic_valid & (auto_cnt == AW'(AUTO_DIV - 1));
  assign req       = auto_en ? auto_wrap : trig_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (!auto_en) begin
      auto_cnt <= '0;
    end else if (cic_valid) begin
      auto_cnt <= auto_wrap ? '0 : auto_cnt + AW'(1);
    end
  end

  // Channel 0 is placed at the top so the whole frame leaves MSB-first by shifting left.
  always_comb begin
    snap_order = '0;
    for (int k = 0; k < NCH; k++) begin
      snap_order[(NCH-1-k)*WIDTH +: WIDTH] = ch_data[k*WIDTH +: WIDTH];
    end
  end

  assign data_phase = (pos_q < PW'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      pos_q   <= '0;
      ch_q    <= '0;
      gap_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      pos_q   <= pos_d;
      ch_q    <= ch_d;
      gap_q   <= gap_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    pos_d   = pos_q;
    ch_d    = ch_q;
    gap_d   = gap_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_ARM;
      end
      S_ARM: begin
        if (cic_valid) begin
          frame_d = snap_order;
          pos_d   = '0;
          ch_d    = '0;
          par_d   = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (data_phase) begin
          frame_d = frame_q << 1;
          par_d   = par_q ^ frame_q[FW-1];
        end
        if (pos_q == PW'(WLEN - 1)) begin
          pos_d = '0;
          par_d = 1'b0;
          if (ch_q == 2'(NCH - 1)) begin
            state_d = S_IDLE;
          end else if (GAP > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          ch_d    = ch_q + 2'd1;
          state_d = S_SHIFT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (req && (state_q != S_IDLE)) begin
      overrun <= 1'b1;
    end
  end

  // Outputs decode registered state only, so reset forces them low immediately.
  assign busy       = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign ser_out    = (state_q == S_SHIFT) && (data_phase ? frame_q[FW-1] : par_q);
  assign word_start = (state_q == S_SHIFT) && (pos_q == '0);
  assign ch_id      = busy ? ch_q : 2'd0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_adc_readout_scheduler.sv
// Randomised scoreboard bench for adc_readout_scheduler; honours PARITY_EN when defined.
module tb_adc_readout_scheduler;

  localparam int NCH      = 3;
  localparam int WIDTH    = 16;
  localparam int GAP      = 2;
  localparam int AUTO_DIV = 4;
`ifdef PARITY_EN
  localparam int WLEN = WIDTH + 1;
`else
  localparam int WLEN = WIDTH;
`endif
  localparam int PERIOD    = WLEN + GAP;
  localparam int FRAME_LEN = NCH * WLEN + (NCH - 1) * GAP;
  localparam int FW        = NCH * WIDTH;
  localparam int EW        = 2 + WLEN;

  logic          clk, rst_n, cic_valid, trig, auto_en;
  logic [FW-1:0] ch_data;
  logic          ser_out, word_start, busy, overrun;
  logic [1:0]    ch_id, dbg_state;

  logic [EW-1:0] exp_q[$];
  int            snap_q[$];
  int            checks = 0, failures = 0;
  int            cyc = 0, frames_exp = 0, frames_done = 0;
  logic          exp_overrun = 1'b0;

  adc_readout_scheduler #(
    .NCH(NCH), .WIDTH(WIDTH), .GAP(GAP), .AUTO_DIV(AUTO_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cic_valid(cic_valid), .ch_data(ch_data),
    .trig(trig), .auto_en(auto_en), .ser_out(ser_out), .word_start(word_start),
    .ch_id(ch_id), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rand_data();
    logic [FW-1:0] d;
    d = '0;
    d[31:0]  = $urandom();
    d[47:32] = 16'($urandom());
    return d;
  endfunction

  function automatic logic [EW-1:0] exp_entry(input int k, input logic [WIDTH-1:0] w);
`ifdef PARITY_EN
    return {2'(k), w, ^w};
`else
    return {2'(k), w};
`endif
  endfunction

  // Reference: one snapshot yields NCH words in channel order, each tagged with its channel.
  task automatic push_frame(input logic [FW-1:0] data);
    for (int k = 0; k < NCH; k++) exp_q.push_back(exp_entry(k, data[k*WIDTH +: WIDTH]));
    snap_q.push_back(cyc);
    frames_exp++;
  endtask

  // Pin rises before edge 1; the request is seen at edge 3, so only a strobe at
  // edge 4 or later snapshots. A strobe at edge d <= 3 must be ignored.
  task automatic trig_frame(input logic [FW-1:0] data, input int d);
    int snap_e;
    snap_e = (d >= 4) ? d : 5;
    for (int e = 1; e <= snap_e; e++) begin
      trig      = (e <= 2);
      cic_valid = (e == d) || (e == snap_e);
      ch_data   = (e == snap_e) ? data : rand_data();
      tick();
    end
    trig      = 1'b0;
    cic_valid = 1'b0;
    push_frame(data);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
    check("overrun", overrun, exp_overrun);
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  // monitor: frame structure per cycle plus word scoreboard
  initial begin
    int            off;
    int            pos;
    int            wi;
    logic          busy_prev;
    logic [WLEN-1:0] acc;
    logic [EW-1:0] e;
    off = 0;
    busy_prev = 1'b0;
    acc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev = 1'b0;
        off = 0;
      end else begin
        if (busy) begin
          if (!busy_prev) begin
            off = 0;
            if (snap_q.size() == 0) check("unexpected_frame", 1, 0);
            else check("snap_latency", cyc, snap_q.pop_front());
          end
          pos = off % PERIOD;
          wi  = off / PERIOD;
          if (pos < WLEN) begin
            check("bit_fmt", {word_start, ch_id}, {(pos == 0), 2'(wi)});
            acc = {acc[WLEN-2:0], ser_out};
            if (pos == WLEN - 1) begin
              if (exp_q.size() == 0) check("unexpected_word", 1, 0);
              else begin
                e = exp_q.pop_front();
                check("word", {ch_id, acc}, e);
              end
            end
          end else begin
            check("gap_fmt", {ser_out, word_start, ch_id}, {2'b00, 2'(wi)});
          end
          off++;
        end else if (busy_prev) begin
          check("frame_len", off, FRAME_LEN);
          frames_done++;
        end else begin
          check("idle_out", {ser_out, word_start, ch_id}, 4'b0000);
        end
        busy_prev = busy;
      end
    end
  end

  // stimulus
  initial begin
    logic [FW-1:0] data;
    rst_n = 1'b0; trig = 1'b0; auto_en = 1'b0; cic_valid = 1'b0; ch_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {ser_out, word_start, ch_id, busy, overrun}, 6'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // fixed frame
    trig_frame({16'h00F0, 16'h1234, 16'hA5A5}, 4);
    wait_idle();

    // data changes after the snapshot must not leak into the frame
    data = rand_data();
    trig_frame(data, 4);
    ch_data = ~data;
    cic_valid = 1'b1;
    tick();
    cic_valid = 1'b0;
    repeat (20) tick();
    ch_data = rand_data();
    cic_valid = 1'b1;
    tick();
    cic_valid = 1'b0;
    wait_idle();

    // random frames, including strobes coincident with or before the request
    for (int i = 0; i < 8; i++) begin
      data = rand_data();
      if (i == 2) data = {16'h0003, 16'h0001, 16'hFFFF};
      if (i == 3) data = '0;
      repeat ($urandom_range(2, 8)) tick();
      trig_frame(data, (i < 3) ? i + 1 : $urandom_range(1, 6));
      wait_idle();
    end

    // auto mode: every AUTO_DIV-th strobe requests, the next strobe snapshots
    repeat (4) tick();
    auto_en = 1'b1;
    tick();
    for (int s = 1; s <= 9; s++) begin
      for (int t = 0; t < 19; t++) begin
        trig = (s < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      data = rand_data();
      ch_data = data;
      cic_valid = 1'b1;
      tick();
      cic_valid = 1'b0;
      if (s > 1 && ((s - 1) % AUTO_DIV) == 0) push_frame(data);
      if (s == 9) auto_en = 1'b0;
    end
    wait_idle();
    repeat (6) tick();

    // request during a frame is dropped and latches overrun
    trig_frame(rand_data(), 4);
    repeat (10) tick();
    trig = 1'b1;
    tick();
    tick();
    trig = 1'b0;
    exp_overrun = 1'b1;
    repeat (5) tick();
    check("overrun_set", overrun, 1);
    wait_idle();
    repeat (6) tick();
    cic_valid = 1'b1;
    tick();
    cic_valid = 1'b0;
    repeat (6) tick();
    cic_valid = 1'b1;
    tick();
    cic_valid = 1'b0;
    tick();
    check("no_second_frame", busy, 0);
    repeat (4) tick();
    trig_frame(rand_data(), 6);
    wait_idle();

    // asynchronous reset in the middle of channel 1
    repeat (4) tick();
    trig_frame(rand_data(), 5);
    repeat (PERIOD + 5) tick();
    check("mid_ch1", ch_id, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {ser_out, word_start, ch_id, busy, overrun}, 6'd0);
    exp_q.delete();
    snap_q.delete();
    frames_exp--;
    exp_overrun = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    trig_frame({16'hC3C3, 16'h8001, 16'h7FFE}, 4);
    wait_idle();

    repeat (3) tick();
    check("frame_count", frames_done, frames_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
